kb_move_scheduler: RTL and testbench
====================================

# kb_move_scheduler

Keyboard-to-movement controller between the PS/2 receiver and the game logic. Consumes completed scan-code bytes, runs the make/break/extended-prefix protocol, and tracks which of five movement keys are held. Once per frame tick it issues one movement command, so game logic sees exactly one move per frame instead of raw, unsynchronised key bytes.

## Interface
- PREFIX_TIMEOUT, 50000: clocks allowed between a prefix byte (E0/F0) and its follow-up before the FSM abandons the sequence (1 ms at 50 MHz).
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- rx_done_tick  in  1  one-cycle strobe from ps2_rx; rx_data valid this cycle.
- rx_data  in  8  received scan-code byte.
- frame_tick  in  1  one-cycle strobe, once per 1/60 s.
- move  out  3  command: 000 none, 001 up, 010 down, 011 left, 100 right, 101 action.
- move_valid  out  1  one-cycle strobe; move is meaningful this cycle.
- key_held  out  5  held mask; bit0 up, bit1 down, bit2 left, bit3 right, bit4 action.

## Operation
- Key map: up = 1D or E0 75; down = 1B or E0 72; left = 1C or E0 6B; right = 23 or E0 74; action = 29 (non-extended only). All other codes are ignored but still consume protocol state.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
  - IDLE: F0 -> BRK; E0 -> EXT; mapped code -> set key_held bit, record last_key; stay IDLE.
  - BRK: any byte -> clear matching non-extended key bit; -> IDLE.
  - EXT: F0 -> EXT_BRK; mapped extended code -> set bit, record last_key; -> IDLE.
  - EXT_BRK: any byte -> clear matching extended key bit; -> IDLE.
  - E0 received in BRK/EXT_BRK, or F0 received in BRK: byte ignored, -> IDLE.
- Timeout: a 16-bit counter runs in BRK/EXT/EXT_BRK. It clears on every rx_done_tick. At PREFIX_TIMEOUT-1 the FSM goes to IDLE with no mask change.
- Selection at frame_tick:
  - If last_key is held, emit last_key.
  - Otherwise fixed priority action > up > down > left > right.
  - If mask is empty, emit 000.
  - move_valid pulses every frame_tick, even when move = 000.
- Releasing last_key clears last_key to none.
- Re-press of an already held key (typematic repeat) sets the bit again (no change) and refreshes last_key.

## Timing
- Reset values: move = 000, move_valid = 0, key_held = 00000, FSM = IDLE, last_key = none, timeout counter = 0.
- key_held updates on the clock edge that samples rx_done_tick; it is visible the next cycle.
- move/move_valid are registered: frame_tick at cycle N -> move_valid high for exactly cycle N+1.
- Simultaneous rx_done_tick and frame_tick: selection uses the pre-update mask and last_key. The byte is still processed that cycle.
- reset mid-sequence (e.g. after F0) discards the prefix, clears all held keys, and suppresses any move_valid that would fall due the next cycle.
- Back-to-back rx_done_tick on consecutive cycles: each byte is processed. No byte is dropped.

## Structure
- Shared package kb_move_pkg:
  - move code constants (MOVE_NONE … MOVE_ACTION);
  - scan-code constants (SC_BREAK = F0, SC_EXT = E0, key codes);
  - FSM state enum;
  - key-index width.
- One sub-module, kb_scan_lookup: combinational map (byte, extended) -> {hit, key index 0–4}.
- FSM, mask, last_key, timeout counter and frame selection live in kb_move_scheduler.

## Test plan
- Press W (1D), then frame_tick -> move_valid for 1 cycle at N+1, move = 001, key_held = 00001.
- W held, then press D (23), then frame_tick -> move = 100 (last pressed). Send F0 23, then frame_tick -> move = 001 (fallback priority).
- E0 6B, then frame_tick -> move = 011. E0 F0 6B, then frame_tick -> move = 000, key_held = 0.
- F0 only, idle PREFIX_TIMEOUT cycles, then 1C -> FSM back in IDLE; left pressed (key_held = 00100), not released.
- rx_done_tick (29) in the same cycle as frame_tick with empty mask -> move = 000 that frame; next frame move = 101.
- Hold all keys, assert reset one cycle between F0 and its code -> all outputs 0; the next code byte is treated as a make from IDLE.

Source files
------------

// File: rtl/kb_move_pkg.sv
// kb_move_pkg
// Shared constants and types for the keyboard movement scheduler:
// move command codes, PS/2 scan-code bytes, key indices and FSM states.
// No ports.
package kb_move_pkg;

   localparam int KEY_IDX_W = 3;
   localparam int NUM_KEYS  = 5;

   typedef logic [KEY_IDX_W-1:0] key_idx_t;

   // Key indices double as bit positions in the held mask.
   localparam key_idx_t KEY_UP     = 3'd0;
   localparam key_idx_t KEY_DOWN   = 3'd1;
   localparam key_idx_t KEY_LEFT   = 3'd2;
   localparam key_idx_t KEY_RIGHT  = 3'd3;
   localparam key_idx_t KEY_ACTION = 3'd4;
   localparam key_idx_t KEY_NONE   = 3'd7;

   localparam logic [2:0] MOVE_NONE   = 3'b000;
   localparam logic [2:0] MOVE_UP     = 3'b001;
   localparam logic [2:0] MOVE_DOWN   = 3'b010;
   localparam logic [2:0] MOVE_LEFT   = 3'b011;
   localparam logic [2:0] MOVE_RIGHT  = 3'b100;
   localparam logic [2:0] MOVE_ACTION = 3'b101;

   localparam logic [7:0] SC_BREAK     = 8'hF0;
   localparam logic [7:0] SC_EXT       = 8'hE0;
   localparam logic [7:0] SC_UP        = 8'h1D;
   localparam logic [7:0] SC_DOWN      = 8'h1B;
   localparam logic [7:0] SC_LEFT      = 8'h1C;
   localparam logic [7:0] SC_RIGHT     = 8'h23;
   localparam logic [7:0] SC_ACTION    = 8'h29;
   localparam logic [7:0] SC_EXT_UP    = 8'h75;
   localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
   localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
   localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kb_state_e;

   function automatic logic [2:0] key_to_move(input key_idx_t k);
      logic [2:0] m;
      case (k)
         KEY_UP:     m = MOVE_UP;
         KEY_DOWN:   m = MOVE_DOWN;
         KEY_LEFT:   m = MOVE_LEFT;
         KEY_RIGHT:  m = MOVE_RIGHT;
         KEY_ACTION: m = MOVE_ACTION;
         default:    m = MOVE_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/kb_move_scheduler_if.sv
// kb_move_scheduler_if
// Bundles the PS/2 receiver strobes, the frame tick and the movement
// outputs of the scheduler.
//   rx_done_tick / rx_data : completed scan-code byte strobe and value
//   frame_tick             : once-per-frame strobe
//   move / move_valid      : registered command and its one-cycle strobe
//   key_held               : held-key mask (up, down, left, right, action)
// master = stimulus side (receiver + frame timer), slave = scheduler.
interface kb_move_scheduler_if;

   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       frame_tick;
   logic [2:0] move;
   logic       move_valid;
   logic [4:0] key_held;

   modport master (
      output rx_done_tick,
      output rx_data,
      output frame_tick,
      input  move,
      input  move_valid,
      input  key_held
   );

   modport slave (
      input  rx_done_tick,
      input  rx_data,
      input  frame_tick,
      output move,
      output move_valid,
      output key_held
   );

endinterface

// File: rtl/kb_scan_lookup.sv
// kb_scan_lookup
// Combinational scan-code map.
//   code    : received byte
//   ext     : byte followed an E0 prefix
//   hit     : byte is one of the five movement keys in that code set
//   key_idx : key index (valid when hit)
// Action has no extended form.
module kb_scan_lookup
   import kb_move_pkg::*;
(
   input  logic [7:0] code,
   input  logic       ext,
   output logic       hit,
   output key_idx_t   key_idx
);

   always_comb begin
      hit     = 1'b0;
      key_idx = KEY_NONE;
      if (!ext) begin
         case (code)
            SC_UP:     begin hit = 1'b1; key_idx = KEY_UP;     end
            SC_DOWN:   begin hit = 1'b1; key_idx = KEY_DOWN;   end
            SC_LEFT:   begin hit = 1'b1; key_idx = KEY_LEFT;   end
            SC_RIGHT:  begin hit = 1'b1; key_idx = KEY_RIGHT;  end
            SC_ACTION: begin hit = 1'b1; key_idx = KEY_ACTION; end
            default:   ;
         endcase
      end else begin
         case (code)
            SC_EXT_UP:    begin hit = 1'b1; key_idx = KEY_UP;    end
            SC_EXT_DOWN:  begin hit = 1'b1; key_idx = KEY_DOWN;  end
            SC_EXT_LEFT:  begin hit = 1'b1; key_idx = KEY_LEFT;  end
            SC_EXT_RIGHT: begin hit = 1'b1; key_idx = KEY_RIGHT; end
            default:      ;
         endcase
      end
   end

endmodule

// File: rtl/kb_move_scheduler.sv
// kb_move_scheduler
// Runs the PS/2 make/break/extended protocol on received scan-code bytes,
// tracks which movement keys are held, and once per frame tick issues a
// single movement command.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of kb_move_scheduler_if (rx bytes, frame tick,
//           move/move_valid, key_held)
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no prefix pending; bytes are makes or prefixes
// ST_BRK     | F0 seen; next byte releases a normal key
// ST_EXT     | E0 seen; next byte is an extended make or F0
// ST_EXT_BRK | E0 F0 seen; next byte releases an extended key
module kb_move_scheduler
   import kb_move_pkg::*;
#(
   parameter int PREFIX_TIMEOUT = 50000
)(
   input  logic                clk,
   input  logic                reset,
   kb_move_scheduler_if.slave  bus
);

   localparam logic [15:0] TO_LAST = 16'(PREFIX_TIMEOUT - 1);

   kb_state_e              state_q, state_d;
   logic [NUM_KEYS-1:0]    held_q, held_d;
   key_idx_t               last_q, last_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [2:0]             move_q, move_d;
   logic                   valid_q, valid_d;

   logic                   lk_ext;
   logic                   lk_hit;
   key_idx_t               lk_idx;
   logic [2:0]             sel_move;

   assign lk_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

   kb_scan_lookup u_lookup (
      .code    (bus.rx_data),
      .ext     (lk_ext),
      .hit     (lk_hit),
      .key_idx (lk_idx)
   );

   // Frame selection always works from the registered mask, so a byte
   // arriving on the same cycle as frame_tick only affects the next frame.
   always_comb begin
      sel_move = MOVE_NONE;
      if (last_q != KEY_NONE && held_q[last_q]) begin
         sel_move = key_to_move(last_q);
      end else if (held_q[KEY_ACTION]) begin
         sel_move = MOVE_ACTION;
      end else if (held_q[KEY_UP]) begin
         sel_move = MOVE_UP;
      end else if (held_q[KEY_DOWN]) begin
         sel_move = MOVE_DOWN;
      end else if (held_q[KEY_LEFT]) begin
         sel_move = MOVE_LEFT;
      end else if (held_q[KEY_RIGHT]) begin
         sel_move = MOVE_RIGHT;
      end
   end

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      move_d  = MOVE_NONE;
      valid_d = 1'b0;

      if (bus.frame_tick) begin
         valid_d = 1'b1;
         move_d  = sel_move;
      end

      if (bus.rx_done_tick) begin
         cnt_d = 16'd0;
         case (state_q)
            ST_IDLE: begin
               if (bus.rx_data == SC_BREAK) begin
                  state_d = ST_BRK;
               end else if (bus.rx_data == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (lk_hit) begin
                  held_d[lk_idx] = 1'b1;
                  last_d         = lk_idx;
               end
            end
            ST_EXT: begin
               if (bus.rx_data == SC_BREAK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  state_d = ST_IDLE;
                  if (lk_hit) begin
                     held_d[lk_idx] = 1'b1;
                     last_d         = lk_idx;
                  end
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               // A stray prefix here abandons the sequence instead of nesting.
               state_d = ST_IDLE;
               if (bus.rx_data != SC_EXT && bus.rx_data != SC_BREAK && lk_hit) begin
                  held_d[lk_idx] = 1'b0;
                  if (last_q == lk_idx) begin
                     last_d = KEY_NONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (cnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         held_q  <= '0;
         last_q  <= KEY_NONE;
         cnt_q   <= 16'd0;
         move_q  <= MOVE_NONE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         move_q  <= move_d;
         valid_q <= valid_d;
      end
   end

   assign bus.move       = move_q;
   assign bus.move_valid = valid_q;
   assign bus.key_held   = held_q;

endmodule

// File: tb/tb_kb_move_scheduler.sv
// tb_kb_move_scheduler
// Directed bench for kb_move_scheduler. A behavioural model (pending-prefix
// flags, an idle-age count and a held-key array) predicts key_held and
// move/move_valid every cycle; literal expectations pin key scenarios.
module tb_kb_move_scheduler;

   localparam int TO = 100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   started = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   kb_move_scheduler_if bus();

   kb_move_scheduler #(.PREFIX_TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- behavioural model ----------------
   bit [4:0] m_held;
   int       m_last;
   bit       m_brk, m_ext;
   int       m_age;
   bit       m_valid;
   bit [2:0] m_move;

   function automatic int key_of(input bit [7:0] b, input bit e);
      if (!e) begin
         case (b)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            8'h29: return 4;
            default: return -1;
         endcase
      end
      case (b)
         8'h75: return 0;
         8'h72: return 1;
         8'h6B: return 2;
         8'h74: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic bit [2:0] choose();
      int prio[5] = '{4, 0, 1, 2, 3};
      if (m_last >= 0 && m_held[m_last]) return 3'(m_last + 1);
      foreach (prio[i]) if (m_held[prio[i]]) return 3'(prio[i] + 1);
      return 3'd0;
   endfunction

   task automatic model_byte(input bit [7:0] b);
      int k;
      if (!m_brk && !m_ext) begin
         if (b == 8'hF0) begin m_brk = 1; m_age = 0; end
         else if (b == 8'hE0) begin m_ext = 1; m_age = 0; end
         else begin
            k = key_of(b, 0);
            if (k >= 0) begin m_held[k] = 1; m_last = k; end
         end
      end else if (m_brk && !m_ext) begin
         k = key_of(b, 0);
         if (b != 8'hE0 && b != 8'hF0 && k >= 0) begin
            m_held[k] = 0;
            if (m_last == k) m_last = -1;
         end
         m_brk = 0;
      end else if (m_ext && !m_brk) begin
         if (b == 8'hF0) begin m_brk = 1; m_age = 0; end
         else begin
            k = key_of(b, 1);
            if (k >= 0) begin m_held[k] = 1; m_last = k; end
            m_ext = 0;
         end
      end else begin
         k = key_of(b, 1);
         if (b != 8'hE0 && k >= 0) begin
            m_held[k] = 0;
            if (m_last == k) m_last = -1;
         end
         m_brk = 0;
         m_ext = 0;
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_held = '0; m_last = -1; m_brk = 0; m_ext = 0; m_age = 0;
         m_valid = 0; m_move = 0;
      end else begin
         if (bus.frame_tick) begin
            m_valid = 1;
            m_move  = choose();
         end else begin
            m_valid = 0;
            m_move  = 0;
         end
         if (bus.rx_done_tick) begin
            model_byte(bus.rx_data);
         end else if (m_brk || m_ext) begin
            m_age++;
            if (m_age == TO) begin m_brk = 0; m_ext = 0; end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_key_held", 8'(bus.key_held), 8'(m_held));
         chk("model_move_valid", 8'(bus.move_valid), 8'(m_valid));
         if (m_valid) chk("model_move", 8'(bus.move), 8'(m_move));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = b;
      tick();
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic frame_lit(input string name, input logic [2:0] exp);
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      chk({name, "_valid"}, 8'(bus.move_valid), 8'd1);
      chk(name, 8'(bus.move), 8'(exp));
      tick();
      chk({name, "_valid_drop"}, 8'(bus.move_valid), 8'd0);
   endtask

   initial begin
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      bus.frame_tick   = 1'b0;
      reset = 1'b1;
      tick();
      started = 1'b1;
      repeat (2) tick();
      chk("rst_key_held", 8'(bus.key_held), 8'h00);
      chk("rst_move_valid", 8'(bus.move_valid), 8'h00);
      chk("rst_move", 8'(bus.move), 8'h00);
      reset = 1'b0;
      tick();

      // W press
      send(8'h1D);
      chk("w_key_held", 8'(bus.key_held), 8'h01);
      frame_lit("w_move", 3'b001);

      // D press while W held, then release D
      send(8'h23);
      frame_lit("d_last_move", 3'b100);
      send(8'hF0); send(8'h23);
      frame_lit("d_rel_move", 3'b001);
      chk("d_rel_key_held", 8'(bus.key_held), 8'h01);
      send(8'hF0); send(8'h1D);
      chk("w_rel_key_held", 8'(bus.key_held), 8'h00);

      // Extended left make/break
      send(8'hE0); send(8'h6B);
      frame_lit("ext_left_move", 3'b011);
      send(8'hE0); send(8'hF0); send(8'h6B);
      chk("ext_rel_key_held", 8'(bus.key_held), 8'h00);
      frame_lit("ext_rel_move", 3'b000);

      // Prefix timeout: F0 abandoned, 1C becomes a make
      send(8'hF0);
      repeat (TO) tick();
      send(8'h1C);
      chk("timeout_key_held", 8'(bus.key_held), 8'h04);
      frame_lit("timeout_move", 3'b011);
      // One cycle short of timeout: still a release
      send(8'hF0);
      repeat (TO - 1) tick();
      send(8'h1C);
      chk("pre_timeout_key_held", 8'(bus.key_held), 8'h00);

      // Byte and frame tick together on an empty mask
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = 8'h29;
      bus.frame_tick   = 1'b1;
      tick();
      bus.rx_done_tick = 1'b0;
      bus.frame_tick   = 1'b0;
      chk("simul_valid", 8'(bus.move_valid), 8'h01);
      chk("simul_move", 8'(bus.move), 8'h00);
      chk("simul_key_held", 8'(bus.key_held), 8'h10);
      frame_lit("simul_next_move", 3'b101);

      // All keys held, reset between F0 and its code
      send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
      chk("all_key_held", 8'(bus.key_held), 8'h1F);
      frame_lit("all_move", 3'b100);
      send(8'hF0);
      reset = 1'b1;
      bus.frame_tick = 1'b1;
      tick();
      reset = 1'b0;
      bus.frame_tick = 1'b0;
      chk("rst_mid_valid", 8'(bus.move_valid), 8'h00);
      chk("rst_mid_move", 8'(bus.move), 8'h00);
      chk("rst_mid_key_held", 8'(bus.key_held), 8'h00);
      send(8'h1D);
      chk("after_rst_key_held", 8'(bus.key_held), 8'h01);
      frame_lit("after_rst_move", 3'b001);

      // Back-to-back bytes
      bus.rx_done_tick = 1'b1;
      bus.rx_data = 8'hE0; tick();
      bus.rx_data = 8'h74; tick();
      bus.rx_data = 8'h1B; tick();
      bus.rx_done_tick = 1'b0;
      chk("b2b_key_held", 8'(bus.key_held), 8'h0B);
      frame_lit("b2b_move", 3'b010);
      // Extended action is not a key
      send(8'hE0); send(8'h29);
      chk("ext_action_key_held", 8'(bus.key_held), 8'h0B);
      // Typematic repeat refreshes last key
      send(8'h1D);
      frame_lit("repeat_move", 3'b001);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
